digit_serial_addsub: RTL and testbench
======================================

DIGIT_SERIAL_ADDSUB -- requirements
Module: digit_serial_addsub

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL provide parameter DIGIT, default 8, bits processed per RUN cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 SHALL provide port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 SHALL provide port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL provide port in_valid, input, 1, operands and op are valid.
REQ-006 SHALL provide port in_ready, output, 1, block can accept an operation.
REQ-007 SHALL provide port A, input, WIDTH, first operand, two's complement.
REQ-008 SHALL provide port B, input, WIDTH, second operand, two's complement.
REQ-009 SHALL provide port sub, input, 1: 0 computes A+B, 1 computes A-B.
REQ-010 SHALL provide port out_valid, output, 1, result, carry_out and overflow are valid.
REQ-011 SHALL provide port out_ready, input, 1, consumer accepts the result.
REQ-012 SHALL provide port result, output, WIDTH, sum or difference modulo 2^WIDTH.
REQ-013 SHALL provide port carry_out, output, 1, carry from the MSB of A + (B or ~B) + sub.
REQ-014 SHALL provide port overflow, output, 1, signed overflow flag.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 In IDLE, in_valid=1 at a rising edge SHALL capture A, B (B inverted when sub=1), set the carry register to sub, clear the digit counter, and enter RUN.
REQ-018 Each RUN cycle SHALL add one DIGIT-bit slice, LSB slice first, using the registered carry, store the slice sum into result, and update the carry register.
REQ-019 RUN SHALL last exactly WIDTH/DIGIT cycles (4 at defaults); out_valid SHALL assert on the edge after the last slice, i.e. WIDTH/DIGIT edges after the accept edge.
REQ-020 carry_out SHALL equal the final carry register value; for sub=1, carry_out=1 means no borrow.
REQ-021 overflow SHALL be 1 iff the MSBs of A and the effective B (B or ~B) are equal and the result MSB differs from them.
REQ-022 In DONE, result, carry_out and overflow SHALL hold stable until out_valid && out_ready at a rising edge; the FSM then returns to IDLE.
REQ-023 No new operation SHALL be accepted in the cycle the result is consumed; in_ready rises on the following cycle.
REQ-024 Changes on A, B, sub or in_valid outside IDLE SHALL have no effect on the operation in progress.
REQ-025 out_ready SHALL be ignored outside DONE.

Reset
REQ-026 rst=1 SHALL force, without waiting for clk: state IDLE, in_ready=1, out_valid=0, result=0, carry_out=0, overflow=0, digit counter=0, carry register=0.
REQ-027 Reset asserted in RUN or DONE SHALL discard the operation; no out_valid SHALL be produced for it.
REQ-028 After rst deasserts, the first rising edge with in_valid=1 SHALL be accepted normally.

Verification
REQ-029 A=0x7FFFFFFF, B=0x00000001, sub=0 -> after 4 RUN cycles result=0x80000000, carry_out=0, overflow=1.
REQ-030 A=0xFFFFFFFF, B=0x80000000, sub=0 -> result=0x7FFFFFFF, carry_out=1, overflow=1.
REQ-031 A=0x00000002, B=0x00000005, sub=1 -> result=0xFFFFFFFD, carry_out=0, overflow=0; A=0x80000000, B=0x00000001, sub=1 -> result=0x7FFFFFFF, carry_out=1, overflow=1.
REQ-032 Backpressure: A=0x0C, B=0x19, sub=0 with out_ready=0 for 10 cycles -> out_valid held, result=0x00000025 stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1 the cycle after.
REQ-033 Reset mid-RUN: accept A=0xFFFFFFFB, B=0xFFFFFFF4, sub=0, assert rst after 2 RUN cycles -> outputs zero immediately, no out_valid; a fresh operation then yields result=0xFFFFFFEF, carry_out=1, overflow=0.
REQ-034 Input change during RUN: alter A, B, sub on every RUN cycle -> result matches the operands captured at the accept edge.

Source files
------------

// File: rtl/digit_serial_addsub.sv
// ---------------------------------------------------------------------------
// digit_serial_addsub
//
// Two's-complement adder/subtractor that processes DIGIT bits per clock.
// An operation is accepted in IDLE, takes WIDTH/DIGIT RUN cycles (LSB slice
// first, ripple carry held in a register between slices) and is then held
// in DONE until the consumer takes it.
//
// Parameters
//   WIDTH      operand / result width in bits
//   DIGIT      bits per RUN cycle; WIDTH must be an integer multiple of DIGIT
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   A, B and sub are valid
//   in_ready   block can accept an operation (IDLE only)
//   A, B       operands, two's complement
//   sub        0: A+B, 1: A-B
//   out_valid  result, carry_out, overflow are valid (DONE only)
//   out_ready  consumer accepts the result
//   result     sum or difference modulo 2^WIDTH
//   carry_out  carry from the MSB of A + (B or ~B) + sub (sub=1: 1 = no borrow)
//   overflow   signed overflow
// ---------------------------------------------------------------------------
module digit_serial_addsub #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;        // effective B: already inverted for sub
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic               ovf_q;

    logic [DIGIT:0]     slice_sum_d;
    logic [WIDTH-1:0]   result_d;
    logic               last_slice;

    // Operands are shifted right one digit per RUN cycle, so the slice being
    // added is always the low DIGIT bits; on the last slice those low bits
    // are the original MSB slice, which is what the overflow rule needs.
    assign slice_sum_d = {1'b0, a_q[DIGIT-1:0]}
                       + {1'b0, b_q[DIGIT-1:0]}
                       + {{DIGIT{1'b0}}, carry_q};

    // Result fills from the top: after NSLICE shifts the first slice sits in
    // the least significant position.
    assign result_d   = WIDTH'({slice_sum_d[DIGIT-1:0], result_q} >> DIGIT);
    assign last_slice = (cnt_q == CNT_W'(NSLICE - 1));

    // NOTE: every register here (including the operand/result datapath) is
    // reset so the outputs read zero the moment rst rises; state is updated
    // with non-blocking assignments only, so all reads in this block see the
    // pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q        <= A;
                        b_q        <= sub ? ~B : B;
                        carry_q    <= sub;      // +1 completes the two's complement
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end

                S_RUN: begin
                    a_q      <= a_q >> DIGIT;
                    b_q      <= b_q >> DIGIT;
                    result_q <= result_d;
                    carry_q  <= slice_sum_d[DIGIT];
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_slice) begin
                        // Operand MSBs agree but the sum MSB differs.
                        ovf_q       <= (a_q[DIGIT-1] == b_q[DIGIT-1]) &&
                                       (slice_sum_d[DIGIT-1] != a_q[DIGIT-1]);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end

                S_DONE: begin
                    // in_ready rises only after the consume edge, so nothing
                    // is accepted in the cycle the result is taken.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
module tb_digit_serial_addsub;

    localparam int WIDTH  = 32;
    localparam int DIGIT  = 8;
    localparam int NSLICE = WIDTH / DIGIT;
    localparam longint SMAX = 64'sh7FFF_FFFF;
    localparam longint SMIN = -SMAX - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    digit_serial_addsub #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             cy;
        logic             ovf;
        int               acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   bp_hold = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the whole operands.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic s, input int acc);
        exp_t   m;
        longint sx, sy, sr;
        m.res = s ? x - y : x + y;
        // Add: carry when the unsigned sum exceeds 2^WIDTH-1.
        // Sub: carry means no borrow, i.e. x >= y unsigned.
        m.cy  = s ? (x >= y) : (({1'b0, x} + {1'b0, y}) > {1'b0, {WIDTH{1'b1}}});
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sr = s ? sx - sy : sx + sy;
        m.ovf = (sr > SMAX) || (sr < SMIN);
        m.acc_cyc = acc;
        return m;
    endfunction

    // Driver: waits for in_ready, presents one operation, optionally
    // scrambles the inputs through the RUN phase.
    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic s, input bit scramble);
        int waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
            return;
        end
        a = x; b = y; sub = s; in_valid = 1'b1;
        exp_q.push_back(model(x, y, s, cyc + 1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (scramble) begin
            for (int i = 0; i < NSLICE; i++) begin
                a = $urandom; b = $urandom; sub = 1'($urandom); in_valid = 1'($urandom);
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drained();
        int n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", (exp_q.size() == 0 && in_ready) ? 1 : 0, 1);
    endtask

    // Monitor: pops the expected response when a new result appears and
    // keeps comparing it while the result is held under backpressure.
    initial begin : monitor
        exp_t cur;
        bit   holding = 0;
        bit   just_consumed = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                holding = 0;
                just_consumed = 0;
                out_ready = 1'b0;
            end else begin
                if (just_consumed) begin
                    check("post_consume_out_valid", out_valid, 0);
                    check("post_consume_in_ready", in_ready, 1);
                    just_consumed = 0;
                end
                if (out_valid) begin
                    check("in_ready_in_done", in_ready, 0);
                    if (!holding) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_out_valid", 1, 0);
                        end else begin
                            cur = exp_q.pop_front();
                            holding = 1;
                            check("result", result, cur.res);
                            check("carry_out", carry_out, cur.cy);
                            check("overflow", overflow, cur.ovf);
                            check("latency", cyc - cur.acc_cyc, NSLICE);
                        end
                    end else begin
                        check("held_result", result, cur.res);
                        check("held_carry", carry_out, cur.cy);
                        check("held_overflow", overflow, cur.ovf);
                    end
                    if (bp_hold > 0) begin
                        out_ready = 1'b0;
                        bp_hold--;
                    end else begin
                        out_ready = ($urandom_range(0, 2) != 0);
                    end
                    if (out_ready) begin
                        holding = 0;
                        just_consumed = 1;
                    end
                end else begin
                    // Random out_ready outside DONE must be ignored.
                    out_ready = 1'($urandom);
                end
            end
        end
    end

    initial begin : stim
        // Reset state
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_carry", carry_out, 0);
        check("rst_overflow", overflow, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed boundary vectors
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        issue(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);
        issue(32'h0000_0002, 32'h0000_0005, 1'b1, 1'b0);
        issue(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
        wait_drained();

        // Backpressure: result held for 10 cycles
        bp_hold = 10;
        issue(32'h0000_000C, 32'h0000_0019, 1'b0, 1'b0);
        wait_drained();
        check("bp_all_used", bp_hold, 0);

        // Reset in the middle of RUN discards the operation
        issue(32'hFFFF_FFFB, 32'hFFFF_FFF4, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        void'(exp_q.pop_back());
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", result, 0);
        check("midrst_carry", carry_out, 0);
        check("midrst_overflow", overflow, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);   // monitor flags any stray out_valid
        issue(32'hFFFF_FFFB, 32'hFFFF_FFF4, 1'b0, 1'b0);
        wait_drained();

        // Inputs changing during RUN
        issue(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b1);
        issue(32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 1'b1);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            logic [WIDTH-1:0] x, y;
            case ($urandom_range(0, 4))
                0: x = '0;
                1: x = '1;
                2: x = 32'h8000_0000;
                3: x = 32'h7FFF_FFFF;
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: y = '0;
                1: y = '1;
                2: y = 32'h8000_0000;
                3: y = 32'h7FFF_FFFF;
                default: y = $urandom;
            endcase
            issue(x, y, 1'($urandom), 1'($urandom));
        end
        wait_drained();
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
